// File: rtl/jts16_tilemap.sv
// Scrolling tile layer: CPU-writable tile map, H/V scroll, per-tile SDRAM fetch and
// a nibble shifter that feeds palette-indexed pixels plus priority to the colour mixer.
module jts16_tilemap #(
    parameter int CODEW  = 12,
    parameter int PALW   = 3,
    parameter int MAP_AW = 11,
    parameter int COLW   = 6,
    parameter int BPP    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pxl2_cen,
    input  logic              pxl_cen,
    input  logic              map_cs,
    input  logic              scr_cs,
    input  logic [MAP_AW-1:0] cpu_addr,
    input  logic [15:0]       cpu_dout,
    input  logic [1:0]        dsn,
    output logic [15:0]       cpu_din,
    output logic              rom_cs,
    output logic [CODEW+2:0]  rom_addr,
    input  logic              rom_ok,
    input  logic [31:0]       rom_data,
    input  logic [8:0]        hdump,
    input  logic [8:0]        vdump,
    output logic [PALW+3:0]   pxl,
    output logic              prio,
    output logic              miss
);

    localparam int ROWW = MAP_AW - COLW;
    localparam int EHW  = COLW + 3;
    localparam int EVW  = ROWW + 3;
    localparam logic [3:0] PIX_MASK = (BPP >= 4) ? 4'hF : 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAP  = 2'd1,
        ST_ATTR = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    logic [15:0]       mem [0:(1<<MAP_AW)-1];
    logic [15:0]       vid_rd_q;

    state_t            state_q, state_d;
    logic [MAP_AW-1:0] map_addr_q, map_addr_d;
    logic [2:0]        row_q, row_d;
    logic [8:0]        hscr_q, hscr_d, vscr_q, vscr_d;
    logic [15:0]       cpu_din_q, cpu_din_d;
    logic              rom_cs_q, rom_cs_d;
    logic [CODEW+2:0]  rom_addr_q, rom_addr_d;
    logic              miss_q, miss_d;
    logic [31:0]       nxt_pix_q, nxt_pix_d;
    logic [PALW-1:0]   nxt_pal_q, nxt_pal_d;
    logic              nxt_prio_q, nxt_prio_d;
    logic [31:0]       sh_pix_q, sh_pix_d;
    logic [PALW-1:0]   sh_pal_q, sh_pal_d;
    logic              sh_prio_q, sh_prio_d;
    logic [PALW+3:0]   pxl_q, pxl_d;
    logic              prio_q, prio_d;

    logic [9:0]        hsum_s, vsum_s;
    logic [EHW-1:0]    eh_s;
    logic [EVW-1:0]    ev_s;
    logic [COLW-1:0]   col_s;
    logic [MAP_AW-1:0] map_addr_s;
    logic              trig_s, load_s;
    logic              unused_s;

    // Scrolled coordinates; the fetch always targets the tile after the current one.
    assign hsum_s     = {1'b0, hdump} + {1'b0, hscr_q};
    assign vsum_s     = {1'b0, vdump} + {1'b0, vscr_q};
    assign eh_s       = hsum_s[EHW-1:0];
    assign ev_s       = vsum_s[EVW-1:0];
    assign col_s      = eh_s[EHW-1:3] + {{(COLW-1){1'b0}}, 1'b1};
    assign map_addr_s = {ev_s[EVW-1:3], col_s};
    assign trig_s     = pxl_cen && (eh_s[2:0] == 3'd0);
    assign load_s     = pxl_cen && (eh_s[2:0] == 3'd7);
    assign unused_s   = ^{hsum_s[9:EHW], vsum_s[9:EVW], pxl2_cen};

    // Map RAM: byte-lane CPU writes; the video read returns pre-write data on a collision.
    always_ff @(posedge clk) begin
        if (map_cs && !dsn[1]) mem[cpu_addr][15:8] <= cpu_dout[15:8];
        if (map_cs && !dsn[0]) mem[cpu_addr][7:0]  <= cpu_dout[7:0];
        vid_rd_q <= mem[map_addr_q];
    end

    // CPU readback and scroll register writes.
    always_comb begin
        cpu_din_d = mem[cpu_addr];
        hscr_d    = hscr_q;
        vscr_d    = vscr_q;
        if (scr_cs && !dsn[0]) begin
            if (cpu_addr[0]) vscr_d = cpu_dout[8:0];
            else             hscr_d = cpu_dout[8:0];
        end else begin
            hscr_d = hscr_q;
        end
    end

    // Fetch FSM: map read, ROM request, and abort with a miss when the next tile is due.
    always_comb begin
        state_d    = state_q;
        map_addr_d = map_addr_q;
        row_d      = row_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        miss_d     = 1'b0;
        nxt_pix_d  = nxt_pix_q;
        nxt_pal_d  = nxt_pal_q;
        nxt_prio_d = nxt_prio_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    state_d    = ST_MAP;
                    map_addr_d = map_addr_s;
                    row_d      = ev_s[2:0];
                    nxt_pix_d  = 32'h0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAP:  state_d = ST_ATTR;
            ST_ATTR: begin
                nxt_pal_d  = vid_rd_q[CODEW+PALW-1:CODEW];
                nxt_prio_d = vid_rd_q[15];
                rom_addr_d = {vid_rd_q[CODEW-1:0], row_q};
                rom_cs_d   = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (trig_s) begin
                    miss_d     = 1'b1;
                    rom_cs_d   = 1'b0;
                    nxt_pix_d  = 32'h0;
                    map_addr_d = map_addr_s;
                    row_d      = ev_s[2:0];
                    state_d    = ST_MAP;
                end else if (rom_ok) begin
                    nxt_pix_d = rom_data;
                    rom_cs_d  = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shifter load/shift and registered pixel output; the output samples before the update.
    always_comb begin
        sh_pix_d  = sh_pix_q;
        sh_pal_d  = sh_pal_q;
        sh_prio_d = sh_prio_q;
        pxl_d     = pxl_q;
        prio_d    = prio_q;
        if (load_s) begin
            sh_pix_d  = nxt_pix_q;
            sh_pal_d  = nxt_pal_q;
            sh_prio_d = nxt_prio_q;
        end else if (pxl_cen) begin
            sh_pix_d = {sh_pix_q[27:0], 4'h0};
        end else begin
            sh_pix_d = sh_pix_q;
        end
        if (pxl_cen) begin
            pxl_d  = {sh_pal_q, sh_pix_q[31:28] & PIX_MASK};
            prio_d = sh_prio_q;
        end else begin
            pxl_d = pxl_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            map_addr_q <= '0;
            row_q      <= 3'd0;
            hscr_q     <= 9'd0;
            vscr_q     <= 9'd0;
            cpu_din_q  <= 16'h0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            miss_q     <= 1'b0;
            nxt_pix_q  <= 32'h0;
            nxt_pal_q  <= '0;
            nxt_prio_q <= 1'b0;
            sh_pix_q   <= 32'h0;
            sh_pal_q   <= '0;
            sh_prio_q  <= 1'b0;
            pxl_q      <= '0;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            map_addr_q <= map_addr_d;
            row_q      <= row_d;
            hscr_q     <= hscr_d;
            vscr_q     <= vscr_d;
            cpu_din_q  <= cpu_din_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            miss_q     <= miss_d;
            nxt_pix_q  <= nxt_pix_d;
            nxt_pal_q  <= nxt_pal_d;
            nxt_prio_q <= nxt_prio_d;
            sh_pix_q   <= sh_pix_d;
            sh_pal_q   <= sh_pal_d;
            sh_prio_q  <= sh_prio_d;
            pxl_q      <= pxl_d;
            prio_q     <= prio_d;
        end
    end

    assign cpu_din  = cpu_din_q;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign miss     = miss_q;
    assign pxl      = pxl_q;
    assign prio     = prio_q;

endmodule

// File: tb/tb_jts16_tilemap.sv
// Directed bench for jts16_tilemap: map/scroll/fetch/miss/reset scenarios with
// hand-computed pixel streams and a small delayed-response ROM model.
module tb_jts16_tilemap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pxl2_cen, pxl_cen, map_cs, scr_cs;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_dout, cpu_din;
    logic [1:0]  dsn;
    logic        rom_cs, rom_ok, prio, miss;
    logic [14:0] rom_addr;
    logic [31:0] rom_data;
    logic [8:0]  hdump, vdump;
    logic [6:0]  pxl;
    logic [15:0] rd_val;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic rom_hold = 1'b0;
    int   rom_cnt  = 0;

    always #5 clk = ~clk;

    jts16_tilemap #(.CODEW(12), .PALW(3), .MAP_AW(11), .COLW(6), .BPP(3)) dut (
        .clk(clk), .rst_n(rst_n), .pxl2_cen(pxl2_cen), .pxl_cen(pxl_cen),
        .map_cs(map_cs), .scr_cs(scr_cs), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .dsn(dsn), .cpu_din(cpu_din), .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_ok(rom_ok), .rom_data(rom_data), .hdump(hdump), .vdump(vdump),
        .pxl(pxl), .prio(prio), .miss(miss)
    );

    function automatic logic [31:0] rom_lut(input logic [14:0] a);
        case (a[14:3])
            12'd5:   return 32'h12345678;
            12'd6:   return 32'h87654321;
            12'd7:   return 32'hFEDCBA98;
            default: return 32'h00000000;
        endcase
    endfunction

    // ROM model: answers 4 clocks after a request unless held off.
    initial begin
        rom_ok   = 1'b0;
        rom_data = 32'h0;
        forever begin
            @(negedge clk);
            rom_ok = 1'b0;
            if (rom_cs === 1'b1 && !rom_hold) begin
                if (rom_cnt == 3) begin
                    rom_ok   = 1'b1;
                    rom_data = rom_lut(rom_addr);
                    rom_cnt  = 0;
                end else begin
                    rom_cnt++;
                end
            end else begin
                rom_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pix_edge();
        @(negedge clk);
        pxl2_cen = 1'b1;
        pxl_cen  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pix_rest();
        @(negedge clk);
        pxl2_cen = 1'b0;
        pxl_cen  = 1'b0;
        hdump    = hdump + 9'd1;
        @(negedge clk);
        pxl2_cen = 1'b1;
        @(negedge clk);
        pxl2_cen = 1'b0;
    endtask

    task automatic px_run(input int n);
        for (int i = 0; i < n; i++) begin
            pix_edge();
            pix_rest();
        end
    endtask

    task automatic px_chk(input string tag, input logic [6:0] ep, input logic epr);
        pix_edge();
        check($sformatf("%s_pxl@%0d", tag, hdump), 32'(pxl), 32'(ep));
        check($sformatf("%s_prio@%0d", tag, hdump), 32'(prio), 32'(epr));
        check($sformatf("%s_miss@%0d", tag, hdump), 32'(miss), 32'(1'b0));
        pix_rest();
    endtask

    task automatic px_pix(input string tag, input logic emiss);
        pix_edge();
        check($sformatf("%s_pix@%0d", tag, hdump), 32'(pxl[3:0]), 32'(4'd0));
        check($sformatf("%s_miss@%0d", tag, hdump), 32'(miss), 32'(emiss));
        pix_rest();
    endtask

    task automatic tile_chk(input string tag, input logic [2:0] pal, input logic [31:0] ex,
                            input logic epr);
        for (int i = 0; i < 8; i++) begin
            px_chk(tag, {pal, ex[31-4*i -: 4]}, epr);
        end
    endtask

    task automatic fetch_probe(input string tag, input logic [14:0] exp_addr);
        pix_edge();
        pix_rest();
        check({tag, "_cs"}, 32'(rom_cs), 32'(1'b1));
        check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    endtask

    task automatic cpu_wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        map_cs = 1'b1; cpu_addr = a; cpu_dout = d; dsn = s;
        @(negedge clk);
        map_cs = 1'b0; dsn = 2'b11;
    endtask

    task automatic cpu_rd(input logic [10:0] a, output logic [15:0] d);
        @(negedge clk);
        map_cs = 1'b1; cpu_addr = a; dsn = 2'b11;
        @(posedge clk);
        #1;
        d = cpu_din;
        @(negedge clk);
        map_cs = 1'b0;
    endtask

    task automatic scr_wr(input logic sel, input logic [8:0] v);
        @(negedge clk);
        scr_cs = 1'b1; cpu_addr = {10'd0, sel}; cpu_dout = {7'd0, v}; dsn = 2'b00;
        @(negedge clk);
        scr_cs = 1'b0; dsn = 2'b11;
    endtask

    initial begin
        rst_n = 1'b0; pxl2_cen = 1'b0; pxl_cen = 1'b0; map_cs = 1'b0; scr_cs = 1'b0;
        cpu_addr = 11'd0; cpu_dout = 16'h0; dsn = 2'b11; hdump = 9'd0; vdump = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_din", 32'(cpu_din), 32'h0);
        check("rst_rom_cs", 32'(rom_cs), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_pxl", 32'(pxl), 32'h0);
        check("rst_prio", 32'(prio), 32'h0);
        check("rst_miss", 32'(miss), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2048; i++) cpu_wr(11'(i), 16'h0000, 2'b00);
        cpu_wr(11'd0, 16'h8005, 2'b00);
        cpu_wr(11'd1, 16'h3006, 2'b00);
        cpu_wr(11'd2, 16'h2007, 2'b00);
        cpu_wr(11'd1984, 16'h4007, 2'b00);

        // Byte-lane writes and readback
        cpu_wr(11'd100, 16'h1234, 2'b00);
        cpu_rd(11'd100, rd_val);
        check("cpu_full", 32'(rd_val), 32'h1234);
        cpu_wr(11'd100, 16'hABCD, 2'b01);
        cpu_rd(11'd100, rd_val);
        check("cpu_upper", 32'(rd_val), 32'hAB34);
        cpu_wr(11'd100, 16'h5678, 2'b10);
        cpu_rd(11'd100, rd_val);
        check("cpu_lower", 32'(rd_val), 32'hAB78);

        // No scroll: entry 0 then entry 1
        hdump = 9'd496;
        px_run(8);
        fetch_probe("s1_rom", {12'd5, 3'd0});
        px_run(7);
        tile_chk("s1_t0", 3'd0, 32'h12345670, 1'b1);
        tile_chk("s1_t1", 3'd3, 32'h07654321, 1'b0);

        // hscr=3: tile boundary at hdump[2:0]==5
        scr_wr(1'b0, 9'd3);
        hdump = 9'd496;
        px_run(13);
        tile_chk("s2_t0", 3'd0, 32'h12345670, 1'b1);
        tile_chk("s2_t1", 3'd3, 32'h07654321, 1'b0);

        // vscr wraps rows: vdump=3 fetches row 31, ROM row 3
        scr_wr(1'b0, 9'd0);
        scr_wr(1'b1, 9'h1F8);
        vdump = 9'd3;
        hdump = 9'd496;
        px_run(8);
        fetch_probe("s3_rom", {12'd7, 3'd3});
        px_run(7);
        tile_chk("s3_t0", 3'd4, 32'h76543210, 1'b0);

        // Withheld ROM: one miss, blank tile, next tile correct
        scr_wr(1'b1, 9'd0);
        vdump = 9'd0;
        hdump = 9'd496;
        px_run(10);
        rom_hold = 1'b1;
        px_run(6);
        tile_chk("s4_t0", 3'd0, 32'h12345670, 1'b1);
        px_pix("s4_t1", 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i == 1) rom_hold = 1'b0;
            px_pix("s4_t1", 1'b0);
        end
        tile_chk("s4_t2", 3'd2, 32'h76543210, 1'b0);

        // Reset during WAIT
        rom_hold = 1'b1;
        hdump = 9'd496;
        px_run(8);
        fetch_probe("s6_rom", {12'd5, 3'd0});
        scr_wr(1'b0, 9'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s6_rom_cs", 32'(rom_cs), 32'h0);
        check("s6_rom_addr", 32'(rom_addr), 32'h0);
        check("s6_pxl", 32'(pxl), 32'h0);
        check("s6_prio", 32'(prio), 32'h0);
        check("s6_miss", 32'(miss), 32'h0);
        check("s6_cpu_din", 32'(cpu_din), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rom_hold = 1'b0;
        hdump = 9'd496;
        px_run(16);
        tile_chk("s6_t0", 3'd0, 32'h12345670, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
